// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch unit
//
// Issues instruction-memory reads one at a time. Each read gets a queue slot
// before it goes out, so a response always has somewhere to land. Returned
// words are queued together with the address they were fetched from and
// handed to decode in order. A redirect (flush) empties the queue and
// discards any response still in flight.
//
// Parameters
//   n      PC / address width in bits
//   DEPTH  instruction queue entries (>= 1)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   pc           current program counter from the PC register
//   incr         one-cycle pulse: PC register advances one step
//   flush        redirect; drop queued and in-flight fetches
//   imem_req     memory request valid
//   imem_addr    request address (stable while imem_req=1)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid (earliest the cycle after gnt)
//   imem_rdata   instruction word
//   inst_valid   queue head holds an instruction
//   inst         head instruction
//   inst_pc      address the head instruction came from
//   inst_ready   decode consumes the head when inst_valid&inst_ready
//
// Build option
//   IFETCH_BYPASS_EN  when defined, a response arriving while the queue is
//                     empty is presented on inst/inst_pc in the same cycle;
//                     if decode takes it right away it is never queued.
// ---------------------------------------------------------------------------
module ifetch #(
    parameter int n     = 32,
    parameter int DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [n-1:0]  pc,
    output logic          incr,
    input  logic          flush,
    output logic          imem_req,
    output logic [n-1:0]  imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [n-1:0]  inst_pc,
    input  logic          inst_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;

    logic [n-1:0]   addr_r;
    logic [CW-1:0]  count_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [31:0]    data_mem_r [DEPTH];
    logic [n-1:0]   pc_mem_r   [DEPTH];

    logic           q_valid_s;
    logic           rsp_ok_s;
    logic           bypass_s;
    logic           push_s;
    logic           pop_s;
    logic           grant_s;
    logic           load_addr_s;
    logic [CW-1:0]  occ_after_pop_s;
    logic [CW-1:0]  occ_after_upd_s;

    // Queue pointer advance with wrap at DEPTH (DEPTH need not be a power of 2).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Handshake decodes and occupancy bookkeeping shared by FSM and queue.
    always_comb begin
        q_valid_s = (count_r != {CW{1'b0}});
        rsp_ok_s  = (state_r == S_WAIT) && imem_rvalid && !flush;
        grant_s   = (state_r == S_REQ) && imem_gnt && !flush;
`ifdef IFETCH_BYPASS_EN
        bypass_s  = rsp_ok_s && !q_valid_s;
`else
        bypass_s  = 1'b0;
`endif
        // A bypassed word taken by decode in the same cycle never occupies a slot.
        push_s          = rsp_ok_s && !(bypass_s && inst_ready);
        pop_s           = q_valid_s && inst_ready;
        occ_after_pop_s = count_r - CW'(pop_s);
        occ_after_upd_s = count_r + CW'(push_s) - CW'(pop_s);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic. A new request is started only when the queue
    // will still have a free slot to receive its response.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!flush && (occ_after_pop_s < DEPTH_C)) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (flush) begin
                    // A granted request still owes a response; wait it out.
                    state_nxt_s = imem_gnt ? S_DRAIN : S_IDLE;
                end else if (imem_gnt) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt_s = imem_rvalid ? S_IDLE : S_DRAIN;
                end else if (imem_rvalid) begin
                    state_nxt_s = (occ_after_upd_s < DEPTH_C) ? S_REQ : S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                // The response ends the transaction even if another redirect
                // arrives with it; otherwise keep waiting for it.
                if (imem_rvalid) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM outputs: request valid, PC advance pulse, request address.
    always_comb begin
        imem_req    = (state_r == S_REQ);
        incr        = grant_s;
        imem_addr   = addr_r;
        load_addr_s = (state_nxt_s == S_REQ) && (state_r != S_REQ);
    end

    // Request address: captured from pc whenever a new request is started.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r <= {n{1'b0}};
        end else if (load_addr_s) begin
            addr_r <= pc;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Instruction queue storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= 32'd0;
                pc_mem_r[i]   <= {n{1'b0}};
            end
        end else if (flush) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]   <= addr_r;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= occ_after_upd_s;
        end
    end

    // Decode-side view: bypassed response, else queue head, else zeros.
    always_comb begin
        inst_valid = 1'b0;
        inst       = 32'd0;
        inst_pc    = {n{1'b0}};
        if (bypass_s) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = addr_r;
        end else if (q_valid_s) begin
            inst_valid = 1'b1;
            inst       = data_mem_r[rd_ptr_r];
            inst_pc    = pc_mem_r[rd_ptr_r];
        end else begin
            inst_valid = 1'b0;
            inst       = 32'd0;
            inst_pc    = {n{1'b0}};
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch (n=32, DEPTH=2).
// A transaction-level model (queue of {word, address} plus the state of the
// single outstanding read) predicts the outputs every cycle; directed
// scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_ifetch;

    localparam int DEPTH = 2;

    localparam int P_IDLE = 0;  // nothing outstanding, not requesting
    localparam int P_REQ  = 1;  // request on the bus, slot reserved
    localparam int P_LIVE = 2;  // granted, response will be kept
    localparam int P_DEAD = 3;  // granted, response will be thrown away

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } entry_t;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        incr;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks;
    int errors;

    // environment state
    logic        auto_rsp;
    logic        inc_s;
    logic        g_s;
    logic [31:0] g_addr;
    int          incr_cnt;
    int          grant_cnt;
    logic        saw_dead;
    logic [31:0] seen_pcs [$];

    // model state
    entry_t      m_q [$];
    int          m_ph;
    logic [31:0] m_addr;

    ifetch #(.n(32), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .incr        (incr),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: predict outputs for this cycle, compare, then advance one edge.
    initial begin
        entry_t      e;
        int          sz;
        logic        byp;
        logic        e_req;
        logic        e_incr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        m_ph   = P_IDLE;
        m_addr = 32'd0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("m_rst_req",   {63'd0, imem_req},   64'd0);
                chk("m_rst_incr",  {63'd0, incr},       64'd0);
                chk("m_rst_valid", {63'd0, inst_valid}, 64'd0);
                m_q.delete();
                m_ph   = P_IDLE;
                m_addr = 32'd0;
            end else begin
                sz  = m_q.size();
                byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
                byp = (m_ph == P_LIVE) && imem_rvalid && !flush && (sz == 0);
`endif
                e_req   = (m_ph == P_REQ);
                e_incr  = e_req && imem_gnt && !flush;
                e_valid = (sz > 0) || byp;
                e_inst  = 32'd0;
                e_pc    = 32'd0;
                if (byp) begin
                    e_inst = imem_rdata;
                    e_pc   = m_addr;
                end else if (sz > 0) begin
                    e_inst = m_q[0].ins;
                    e_pc   = m_q[0].pc;
                end
                chk("m_req",   {63'd0, imem_req},   {63'd0, e_req});
                chk("m_incr",  {63'd0, incr},       {63'd0, e_incr});
                chk("m_valid", {63'd0, inst_valid}, {63'd0, e_valid});
                if (e_req) chk("m_addr", {32'd0, imem_addr}, {32'd0, m_addr});
                if (e_valid) begin
                    chk("m_inst",    {32'd0, inst},    {32'd0, e_inst});
                    chk("m_inst_pc", {32'd0, inst_pc}, {32'd0, e_pc});
                end
                if (flush) begin
                    m_q.delete();
                    case (m_ph)
                        P_REQ:   m_ph = imem_gnt ? P_DEAD : P_IDLE;
                        P_LIVE:  m_ph = imem_rvalid ? P_IDLE : P_DEAD;
                        P_DEAD:  m_ph = imem_rvalid ? P_IDLE : P_DEAD;
                        default: m_ph = P_IDLE;
                    endcase
                end else begin
                    if ((sz > 0) && inst_ready) void'(m_q.pop_front());
                    case (m_ph)
                        P_IDLE: if (m_q.size() < DEPTH) begin
                            m_ph = P_REQ; m_addr = pc;
                        end
                        P_REQ: if (imem_gnt) m_ph = P_LIVE;
                        P_LIVE: if (imem_rvalid) begin
                            if (!(byp && inst_ready)) begin
                                e.ins = imem_rdata;
                                e.pc  = m_addr;
                                m_q.push_back(e);
                            end
                            if (m_q.size() < DEPTH) begin
                                m_ph = P_REQ; m_addr = pc;
                            end else begin
                                m_ph = P_IDLE;
                            end
                        end
                        P_DEAD: if (imem_rvalid) m_ph = P_IDLE;
                        default: m_ph = P_IDLE;
                    endcase
                end
            end
        end
    end

    // One clock: observe at the falling edge, then act as PC register and
    // memory just after the rising edge.
    task automatic step();
        @(negedge clock);
        inc_s = incr;
        if (incr) incr_cnt++;
        g_s = imem_req && imem_gnt;
        if (g_s) begin
            grant_cnt++;
            g_addr = imem_addr;
        end
        if (reset && inst_valid && inst_ready) seen_pcs.push_back(inst_pc);
        if (inst_valid && (inst == 32'hDEADBEEF)) saw_dead = 1'b1;
        @(posedge clock);
        #1;
        if (inc_s) pc = pc + 32'd1;
        if (auto_rsp) begin
            imem_rvalid = g_s;
            imem_rdata  = 32'hA000_0000 | g_addr;
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req"},   {63'd0, imem_req},   64'd0);
        chk({tag, "_incr"},  {63'd0, incr},       64'd0);
        chk({tag, "_valid"}, {63'd0, inst_valid}, 64'd0);
        chk({tag, "_addr"},  {32'd0, imem_addr},  64'd0);
        chk({tag, "_inst"},  {32'd0, inst},       64'd0);
        chk({tag, "_pc"},    {32'd0, inst_pc},    64'd0);
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset       = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        inst_ready  = 1'b0;
        auto_rsp    = 1'b0;
        pc          = start_pc;
        steps(2);
        chk_zero_outputs("reset");
        reset     = 1'b1;
        incr_cnt  = 0;
        grant_cnt = 0;
        saw_dead  = 1'b0;
        seen_pcs.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        g_addr = 32'd0;

        // 1: streaming with gnt tied high and rvalid the cycle after gnt.
        do_reset(32'h10);
        imem_gnt = 1'b1; inst_ready = 1'b1; auto_rsp = 1'b1;
        steps(8);
        chk("t1_consumed", seen_pcs.size(), 64'd3);
        for (int i = 0; i < 3; i++)
            chk("t1_seq", (i < seen_pcs.size()) ? {32'd0, seen_pcs[i]} : 64'hFFFF,
                64'h10 + 64'(i));
        chk("t1_incr_cnt", incr_cnt, 64'd4);

        // 2: decode stalled, queue fills after two fetches.
        do_reset(32'h10);
        imem_gnt = 1'b1; inst_ready = 1'b0; auto_rsp = 1'b1;
        steps(12);
        chk("t2_grants",  grant_cnt,                 64'd2);
        chk("t2_req",     {63'd0, imem_req},         64'd0);
        chk("t2_valid",   {63'd0, inst_valid},       64'd1);
        chk("t2_head_pc", {32'd0, inst_pc},          64'h10);
        inst_ready = 1'b1;
        step();
        chk("t2_next_pc", {32'd0, inst_pc},          64'h11);
        chk("t2_req2",    {63'd0, imem_req},         64'd1);
        chk("t2_addr2",   {32'd0, imem_addr},        64'h12);

        // 3: flush in WAIT together with rvalid.
        do_reset(32'h10);
        imem_gnt = 1'b1; inst_ready = 1'b1;
        steps(2);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; flush = 1'b1;
        step();
        imem_rvalid = 1'b0; flush = 1'b0; pc = 32'h20; imem_gnt = 1'b0;
        chk("t3_valid", {63'd0, inst_valid}, 64'd0);
        chk("t3_incr",  incr_cnt,            64'd1);
        step();
        chk("t3_req",  {63'd0, imem_req},  64'd1);
        chk("t3_addr", {32'd0, imem_addr}, 64'h20);
        steps(3);
        chk("t3_dead", {63'd0, saw_dead}, 64'd0);

        // 4: flush in REQ with gnt, response drained, redirect to 0x40.
        do_reset(32'h10);
        imem_gnt = 1'b1; inst_ready = 1'b1;
        step();
        flush = 1'b1; pc = 32'h40;
        step();
        chk("t4_no_incr", incr_cnt, 64'd0);
        flush = 1'b0; imem_gnt = 1'b0;
        chk("t4_drain_req", {63'd0, imem_req}, 64'd0);
        steps(2);
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        chk("t4_idle_req", {63'd0, imem_req}, 64'd0);
        step();
        chk("t4_req",   {63'd0, imem_req},   64'd1);
        chk("t4_addr",  {32'd0, imem_addr},  64'h40);
        chk("t4_valid", {63'd0, inst_valid}, 64'd0);

        // 5: reset during WAIT, stray response afterwards.
        do_reset(32'h10);
        imem_gnt = 1'b1; inst_ready = 1'b1;
        steps(2);
        reset = 1'b0;
        #1;
        chk_zero_outputs("t5_async");
        imem_gnt = 1'b0;
        steps(2);
        reset = 1'b1; pc = 32'h10;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        steps(2);
        imem_rvalid = 1'b0;
        step();
        chk("t5_valid", {63'd0, inst_valid}, 64'd0);
        chk("t5_inst",  {32'd0, inst},       64'd0);

        // 6: response latency to decode with an empty queue.
        do_reset(32'h10);
        imem_gnt = 1'b1; inst_ready = 1'b1;
        steps(2);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; imem_gnt = 1'b0;
        #1;
`ifdef IFETCH_BYPASS_EN
        chk("t6_same_valid", {63'd0, inst_valid}, 64'd1);
        chk("t6_same_inst",  {32'd0, inst},       64'h13);
`else
        chk("t6_same_valid", {63'd0, inst_valid}, 64'd0);
`endif
        step();
        imem_rvalid = 1'b0;
`ifdef IFETCH_BYPASS_EN
        chk("t6_next_valid", {63'd0, inst_valid}, 64'd0);
`else
        chk("t6_next_valid", {63'd0, inst_valid}, 64'd1);
        chk("t6_next_inst",  {32'd0, inst},       64'h13);
        chk("t6_next_pc",    {32'd0, inst_pc},    64'h10);
`endif

        // 7: flush in REQ without gnt, then flush held across WAIT/DRAIN.
        do_reset(32'h30);
        inst_ready = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t7_req_drop", {63'd0, imem_req}, 64'd0);
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; flush = 1'b1;
        steps(2);
        flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        imem_rvalid = 1'b0;
        step();
        chk("t7_req_again", {63'd0, imem_req},   64'd1);
        chk("t7_valid",     {63'd0, inst_valid}, 64'd0);
        steps(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
